// File: rtl/mod_inverse_pkg.sv
// Shared types and constants for the modular-inverse block (d = e^-1 mod phi).
// The optional gcd_out port is controlled by the macro MOD_INVERSE_GCD_OUT_EN
// and is handled in mod_inverse_if.sv and mod_inverse.sv.
package mod_inverse_pkg;

    // Datapath width that matches the upstream 12-bit GCD stage
    localparam int DEFAULT_WIDTH = 12;

    // Controller states of the iterative extended Euclidean loop
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        UPDATE,
        FINAL
    } state_t;

    // Bezout coefficient for e at the default width. It is one bit wider than
    // the datapath because it is signed and its magnitude never exceeds phi.
    typedef logic signed [DEFAULT_WIDTH:0] coef_t;

endpackage : mod_inverse_pkg

// File: rtl/mod_inverse_if.sv
// Request/result bundle for mod_inverse.
// When MOD_INVERSE_GCD_OUT_EN is defined, the bundle also carries gcd_out.
interface mod_inverse_if #(
    parameter int WIDTH = mod_inverse_pkg::DEFAULT_WIDTH
);

    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] phi;
    logic             flag;
    logic [WIDTH-1:0] d;
    logic             valid;
    logic             busy;
    logic             complete;
`ifdef MOD_INVERSE_GCD_OUT_EN
    logic [WIDTH-1:0] gcd_out;
`endif

    // Requester side (key-generation controller or testbench)
    modport master (
        output e, phi, flag,
`ifdef MOD_INVERSE_GCD_OUT_EN
        input  gcd_out,
`endif
        input  d, valid, busy, complete
    );

    // Inverter side
    modport slave (
        input  e, phi, flag,
`ifdef MOD_INVERSE_GCD_OUT_EN
        output gcd_out,
`endif
        output d, valid, busy, complete
    );

endinterface : mod_inverse_if

// File: rtl/mod_inverse_seq_divider.sv
// Restoring divider for mod_inverse. It produces one quotient bit per cycle.
// The first bit is resolved on the start edge. This places the done pulse
// exactly WIDTH cycles after the start cycle, with quotient and remainder
// already final. The divisor is never zero because the caller checks for it.
module seq_divider
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q, done_q;

    logic [WIDTH-1:0] remIn, quoIn, dvsIn;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] remNext, quoNext;

    // One restoring step. The step starts from fresh operands on start and
    // from the running partial remainder otherwise.
    always_comb begin
        remIn   = start ? '0 : rem_q;
        quoIn   = start ? dividend : quo_q;
        dvsIn   = start ? divisor : div_q;
        shifted = {remIn, quoIn[WIDTH-1]};
        trial   = shifted - {1'b0, dvsIn};
        if (trial[WIDTH]) begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remNext = trial[WIDTH-1:0];
            quoNext = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration counter and operand registers. Reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q    <= remNext;
                quo_q    <= quoNext;
                div_q    <= divisor;
                cnt_q    <= CW'(WIDTH - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= remNext;
                quo_q <= quoNext;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule : seq_divider

// File: rtl/mod_inverse.sv
// Computes the RSA private exponent d = e^-1 mod phi with the iterative
// extended Euclidean algorithm. Only the coefficient of e is tracked.
// It also reports whether gcd(e, phi) = 1.
// Defining MOD_INVERSE_GCD_OUT_EN exposes the final gcd on gcd_out.
module mod_inverse
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_inverse_if.slave  bus
);

    state_t state_q, state_d;

    logic [WIDTH-1:0]        r0_q, r0_d, r1_q, r1_d;
    logic signed [WIDTH:0]   t0_q, t0_d, t1_q, t1_d;
    logic [WIDTH-1:0]        q_q, q_d, rem_q, rem_d;
    logic [WIDTH-1:0]        phi_q, phi_d;
    logic                    degen_q, degen_d;
    logic [WIDTH-1:0]        dOut_q, dOut_d;
    logic                    valid_q, valid_d, busy_q, busy_d, complete_q, complete_d;
`ifdef MOD_INVERSE_GCD_OUT_EN
    logic [WIDTH-1:0]        gcdOut_q, gcdOut_d;
`endif

    logic                    divStart, divDone;
    logic [WIDTH-1:0]        divQuo, divRem;
    logic [2*WIDTH:0]        tExt, qExt;
    logic [WIDTH:0]          prodLow;
    logic [WIDTH-1:0]        tWrap;
    logic                    validNext;

    seq_divider #(.WIDTH(WIDTH)) divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (divStart),
        .dividend  (r0_q),
        .divisor   (r1_q),
        .quotient  (divQuo),
        .remainder (divRem),
        .done      (divDone)
    );

    // The q*t1 product is formed at full width. Only the low WIDTH+1 bits are
    // kept. They are exact because |t| never exceeds phi. A negative final
    // coefficient wraps into [0, phi) modulo 2^WIDTH.
    always_comb begin
        tExt    = {{WIDTH{t1_q[WIDTH]}}, t1_q};
        qExt    = {{(WIDTH + 1){1'b0}}, q_q};
        prodLow = (WIDTH + 1)'(tExt * qExt);
        tWrap   = t0_q[WIDTH-1:0] + phi_q;
    end

    // Next-state and datapath logic. A degenerate phi (< 2) still passes
    // through CHECK once, so it follows the same k=0 timing as e=0.
    always_comb begin
        state_d    = state_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        q_d        = q_q;
        rem_d      = rem_q;
        phi_d      = phi_q;
        degen_d    = degen_q;
        dOut_d     = dOut_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        complete_d = complete_q;
`ifdef MOD_INVERSE_GCD_OUT_EN
        gcdOut_d   = gcdOut_q;
`endif
        divStart   = 1'b0;
        validNext  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flag) begin
                    r0_d       = bus.phi;
                    r1_d       = bus.e;
                    t0_d       = '0;
                    t1_d       = (WIDTH + 1)'(1);
                    phi_d      = bus.phi;
                    degen_d    = (bus.phi < WIDTH'(2));
                    busy_d     = 1'b1;
                    complete_d = 1'b0;
                    valid_d    = 1'b0;
                    dOut_d     = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (degen_q || (r1_q == '0)) begin
                    state_d = FINAL;
                end else begin
                    divStart = 1'b1;
                    state_d  = DIV;
                end
            end
            DIV: begin
                if (divDone) begin
                    q_d     = divQuo;
                    rem_d   = divRem;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t0_q - $signed(prodLow);
                state_d = CHECK;
            end
            FINAL: begin
                validNext  = (r0_q == WIDTH'(1)) && !degen_q;
                valid_d    = validNext;
                dOut_d     = validNext ? (t0_q[WIDTH] ? tWrap : t0_q[WIDTH-1:0]) : '0;
                complete_d = 1'b1;
                busy_d     = 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
                gcdOut_d   = r0_q;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset discards every partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r0_q       <= '0;
            r1_q       <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            phi_q      <= '0;
            degen_q    <= 1'b0;
            dOut_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
            gcdOut_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            phi_q      <= phi_d;
            degen_q    <= degen_d;
            dOut_q     <= dOut_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
`ifdef MOD_INVERSE_GCD_OUT_EN
            gcdOut_q   <= gcdOut_d;
`endif
        end
    end

    assign bus.d        = dOut_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.complete = complete_q;
`ifdef MOD_INVERSE_GCD_OUT_EN
    assign bus.gcd_out  = gcdOut_q;
`endif

endmodule : mod_inverse
